key_sched_seq: RTL and testbench

Sequential, parametrised DES round-key scheduler that replaces the fully unrolled 16-stage key generator. A 64-bit key is captured on a start handshake, and one 48-bit round key is streamed per accepted transfer. Each key carries its round index. The block supports encrypt order (K1 first) and decrypt order (KN first), a configurable round count and shift schedule, and an odd-parity check on the key. It sits between the key register and the round datapath of the iterative cipher core.

---
 rtl/key_sched_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_key_sched_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sched_seq.sv
// -----------------------------------------------------------------------------
// key_sched_seq
//   Sequential DES round-key scheduler. A 64-bit key is captured on start and
//   one 48-bit round key (PC-2 of the current C/D halves) is streamed per
//   accepted valid/ready transfer, tagged with its 0-based round index.
//   Encrypt order emits K1..KN. Decrypt order first winds C/D forward to C_N/D_N
//   and then emits KN..K1, un-rotating between keys.
//
// Parameters
//   NUM_ROUNDS   : number of round keys emitted (1..16)
//   SHIFT_MASK   : bit i = 1 -> round i rotates by 2, else by 1
//   CHECK_PARITY : 1 enables the per-byte odd-parity check of the key
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   start         : request a schedule (sampled only in IDLE)
//   decrypt       : order select, captured with start (1 = KN..K1)
//   key           : cipher key, captured with start (DES bit 1 = key[63])
//   abort         : synchronous cancel, returns to IDLE without done
//   busy          : schedule in progress (WIND/EMIT)
//   rk_valid      : round key presented
//   rk_ready      : consumer accepts the presented round key
//   rk_data       : PC-2 of the current C/D state
//   rk_idx        : 0-based round index of the presented key
//   done          : one-cycle pulse after the last key is accepted
//   key_par_err   : bit i = 1 if key byte i has even parity
// -----------------------------------------------------------------------------
module key_sched_seq #(
  parameter int          NUM_ROUNDS   = 16,
  parameter logic [15:0] SHIFT_MASK   = 16'h7EFC,
  parameter bit          CHECK_PARITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic        abort,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [47:0] rk_data,
  output logic [3:0]  rk_idx,
  output logic        done,
  output logic [7:0]  key_par_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WIND = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  // Bit i of the result is 1 when key byte i holds an even number of ones.
  function automatic logic [7:0] even_par_bytes(input logic [63:0] k);
    return {~^k[63:56], ~^k[55:48], ~^k[47:40], ~^k[39:32],
            ~^k[31:24], ~^k[23:16], ~^k[15:8],  ~^k[7:0]};
  endfunction

  // Rotate a 28-bit half left by 1 or by 2 (two = 1).
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  // Rotate a 28-bit half right by 1 or by 2 (two = 1).
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state_r, state_s;
  logic [27:0] c_r, c_s, d_r, d_s;
  logic [27:0] c0_s, d0_s;
  logic [3:0]  idx_r, idx_s, cnt_r, cnt_s;
  logic [3:0]  idx_inc_s;
  logic        dec_r, dec_s;
  logic [7:0]  par_r, par_s;
  logic        busy_r, valid_r, done_r;
  logic        last_s;

  // PC-1: parity bits (DES bits 8,16,..,64 = key[56],key[48],..,key[0]) are dropped.
  assign c0_s = {key[7],  key[15], key[23], key[31], key[39], key[47], key[55],
                 key[63], key[6],  key[14], key[22], key[30], key[38], key[46],
                 key[54], key[62], key[5],  key[13], key[21], key[29], key[37],
                 key[45], key[53], key[61], key[4],  key[12], key[20], key[28]};
  assign d0_s = {key[1],  key[9],  key[17], key[25], key[33], key[41], key[49],
                 key[57], key[2],  key[10], key[18], key[26], key[34], key[42],
                 key[50], key[58], key[3],  key[11], key[19], key[27], key[35],
                 key[43], key[51], key[59], key[36], key[44], key[52], key[60]};

  // PC-2: the first 24 output bits come only from C, the last 24 only from D.
  assign rk_data = {c_r[14], c_r[11], c_r[17], c_r[4],  c_r[27], c_r[23],
                    c_r[25], c_r[0],  c_r[13], c_r[22], c_r[7],  c_r[18],
                    c_r[5],  c_r[9],  c_r[16], c_r[24], c_r[2],  c_r[20],
                    c_r[12], c_r[21], c_r[1],  c_r[8],  c_r[15], c_r[26],
                    d_r[15], d_r[4],  d_r[25], d_r[19], d_r[9],  d_r[1],
                    d_r[26], d_r[16], d_r[5],  d_r[11], d_r[23], d_r[8],
                    d_r[12], d_r[7],  d_r[17], d_r[0],  d_r[22], d_r[3],
                    d_r[10], d_r[14], d_r[6],  d_r[20], d_r[27], d_r[24]};

  assign idx_inc_s   = idx_r + 4'd1;
  // The last key is K_N when encrypting and K1 when decrypting.
  assign last_s      = dec_r ? (idx_r == 4'd0) : (idx_r == LAST_IDX);
  assign rk_idx      = idx_r;
  assign busy        = busy_r;
  assign rk_valid    = valid_r;
  assign done        = done_r;
  assign key_par_err = par_r;

  // Next-state and next-datapath logic for the schedule FSM.
  always_comb begin
    state_s = state_r;
    c_s     = c_r;
    d_s     = d_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    dec_s   = dec_r;
    par_s   = par_r;
    case (state_r)
      ST_IDLE: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (start) begin
          dec_s = decrypt;
          if (CHECK_PARITY) begin
            par_s = even_par_bytes(key);
          end else begin
            par_s = 8'h00;
          end
          if (decrypt) begin
            // Decrypt starts from C0/D0 and winds forward to C_N/D_N first.
            c_s     = c0_s;
            d_s     = d0_s;
            cnt_s   = 4'd0;
            idx_s   = 4'd0;
            state_s = ST_WIND;
          end else begin
            c_s     = rotl28(c0_s, SHIFT_MASK[0]);
            d_s     = rotl28(d0_s, SHIFT_MASK[0]);
            idx_s   = 4'd0;
            state_s = ST_EMIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WIND: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else begin
          c_s   = rotl28(c_r, SHIFT_MASK[cnt_r]);
          d_s   = rotl28(d_r, SHIFT_MASK[cnt_r]);
          cnt_s = cnt_r + 4'd1;
          if (cnt_r == LAST_IDX) begin
            idx_s   = LAST_IDX;
            state_s = ST_EMIT;
          end else begin
            state_s = ST_WIND;
          end
        end
      end
      ST_EMIT: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (rk_ready) begin
          if (last_s) begin
            state_s = ST_DONE;
          end else if (dec_r) begin
            // Undo the rotation that produced the current key.
            c_s   = rotr28(c_r, SHIFT_MASK[idx_r]);
            d_s   = rotr28(d_r, SHIFT_MASK[idx_r]);
            idx_s = idx_r - 4'd1;
          end else begin
            c_s   = rotl28(c_r, SHIFT_MASK[idx_inc_s]);
            d_s   = rotl28(d_r, SHIFT_MASK[idx_inc_s]);
            idx_s = idx_inc_s;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      c_r     <= 28'd0;
      d_r     <= 28'd0;
      idx_r   <= 4'd0;
      cnt_r   <= 4'd0;
      dec_r   <= 1'b0;
      par_r   <= 8'h00;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      c_r     <= c_s;
      d_r     <= d_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      dec_r   <= dec_s;
      par_r   <= par_s;
      busy_r  <= (state_s == ST_WIND) || (state_s == ST_EMIT);
      valid_r <= (state_s == ST_EMIT);
      done_r  <= (state_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_key_sched_seq.sv
// -----------------------------------------------------------------------------
// tb_key_sched_seq
//   Drives two schedulers (default DES parameters and a 4-round, all-single-
//   shift variant) and checks every presented round key against a reference
//   that computes K_r directly from the DES tables and the cumulative shift
//   count of rounds 1..r.
// -----------------------------------------------------------------------------
module tb_key_sched_seq;

  localparam logic [63:0] KEY1   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY2   = 64'h133457799BBCDFF0;
  localparam logic [47:0] DES_K1 = 48'h1B02EFFC7072;
  localparam logic [47:0] DES_K16 = 48'hCB3D8B0E17F5;
  localparam longint unsigned M28 = 64'h0FFFFFFF;

  int pc1_t [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                     10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  int pc2_t [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                     23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                     41,52,31,37,47,55,30,40,51,45,33,48,
                     44,49,39,56,34,53,46,42,50,36,29,32};

  logic        clk, rst, start, decrypt, abort, rk_ready, sel;
  logic [63:0] key;
  logic        start_a, start_b;
  logic        busy_a, valid_a, done_a, busy_b, valid_b, done_b;
  logic [47:0] data_a, data_b;
  logic [3:0]  idx_a, idx_b;
  logic [7:0]  par_a, par_b;
  logic        o_busy, o_valid, o_done;
  logic [47:0] o_data;
  logic [3:0]  o_idx;
  logic [7:0]  o_par;

  int n_checks = 0;
  int n_fails  = 0;
  logic [47:0] seen_q [$];

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  key_sched_seq dut_a (
    .clk(clk), .rst(rst), .start(start_a), .decrypt(decrypt), .key(key),
    .abort(abort), .busy(busy_a), .rk_valid(valid_a), .rk_ready(rk_ready),
    .rk_data(data_a), .rk_idx(idx_a), .done(done_a), .key_par_err(par_a)
  );

  key_sched_seq #(.NUM_ROUNDS(4), .SHIFT_MASK(16'h0000), .CHECK_PARITY(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .decrypt(decrypt), .key(key),
    .abort(abort), .busy(busy_b), .rk_valid(valid_b), .rk_ready(rk_ready),
    .rk_data(data_b), .rk_idx(idx_b), .done(done_b), .key_par_err(par_b)
  );

  always_comb begin
    o_busy  = sel ? busy_b  : busy_a;
    o_valid = sel ? valid_b : valid_a;
    o_done  = sel ? done_b  : done_a;
    o_data  = sel ? data_b  : data_a;
    o_idx   = sel ? idx_b   : idx_a;
    o_par   = sel ? par_b   : par_a;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint unsigned bit_at(longint unsigned v, int w, int p);
    return (v >> (w - p)) & 64'd1;
  endfunction

  function automatic longint unsigned rotl_m(longint unsigned x, int s);
    if (s == 0) return x;
    return ((x << s) | (x >> (28 - s))) & M28;
  endfunction

  function automatic longint unsigned model_rk(longint unsigned k, logic [15:0] mask, int r);
    longint unsigned cd = 0, c, d, out = 0;
    int s = 0;
    for (int j = 0; j < 56; j++) cd = (cd << 1) | bit_at(k, 64, pc1_t[j]);
    c = (cd >> 28) & M28;
    d = cd & M28;
    for (int i = 0; i < r; i++) s += (((mask >> i) & 16'd1) != 16'd0) ? 2 : 1;
    s = s % 28;
    cd = (rotl_m(c, s) << 28) | rotl_m(d, s);
    for (int j = 0; j < 48; j++) out = (out << 1) | bit_at(cd, 56, pc2_t[j]);
    return out;
  endfunction

  function automatic logic [7:0] model_par(longint unsigned k);
    logic [7:0] p = 8'h00;
    for (int b = 0; b < 8; b++)
      if (($countones((k >> (8 * b)) & 64'hFF) % 2) == 0) p = p | (8'd1 << b);
    return p;
  endfunction

  // Run one schedule; abort_idx >= 0 aborts while that index is presented,
  // poke pulses start with a different key/order during emission.
  task automatic run_sched(input bit use_b, input logic [63:0] k, input bit dec,
                           input int ready_pct, input int abort_idx, input bit poke);
    int nr = use_b ? 4 : 16;
    logic [15:0] mask = use_b ? 16'h0000 : 16'h7EFC;
    longint unsigned exp_d [$];
    int exp_i [$];
    int lat, pos, cyc, vcyc;
    bit aborted, rdy;
    for (int r = 1; r <= nr; r++) begin
      if (dec) begin
        exp_d.push_front(model_rk(k, mask, r));
        exp_i.push_front(r - 1);
      end else begin
        exp_d.push_back(model_rk(k, mask, r));
        exp_i.push_back(r - 1);
      end
    end
    seen_q.delete();
    sel = use_b; key = k; decrypt = dec; rk_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check_val("busy_after_start", o_busy, 1);
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("first_valid_latency", lat, dec ? nr + 1 : 1);
    check_val("key_par_err", o_par, model_par(k));
    pos = 0; cyc = 0; vcyc = 0; aborted = 0;
    while (pos < nr && cyc < 600 && !aborted) begin
      check_val("rk_valid", o_valid, 1);
      check_val("rk_idx", o_idx, exp_i[pos]);
      check_val("rk_data", o_data, exp_d[pos]);
      vcyc++;
      if (abort_idx == exp_i[pos]) begin
        abort = 1'b1; rk_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; rk_ready = 1'b0;
        check_val("abort_valid", o_valid, 0);
        check_val("abort_busy", o_busy, 0);
        check_val("abort_done", o_done, 0);
        @(posedge clk); #1;
        check_val("abort_done_next", o_done, 0);
        check_val("abort_valid_next", o_valid, 0);
        aborted = 1;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
        rk_ready = rdy;
        if (rdy) seen_q.push_back(o_data);
        if (poke && pos == 1) begin
          start = 1'b1; key = ~k; decrypt = ~dec;
        end
        @(posedge clk); #1;
        start = 1'b0; key = k; decrypt = dec;
        if (rdy) pos++;
      end
      cyc++;
    end
    rk_ready = 1'b0;
    if (!aborted) begin
      check_val("keys_accepted", pos, nr);
      if (ready_pct >= 100) check_val("valid_cycles", vcyc, nr);
      check_val("done_pulse", o_done, 1);
      check_val("done_valid", o_valid, 0);
      check_val("done_busy", o_busy, 0);
      @(posedge clk); #1;
      check_val("done_clear", o_done, 0);
      check_val("idle_busy", o_busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; abort = 1'b0;
    rk_ready = 1'b0; sel = 1'b0; key = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", o_busy, 0);
    check_val("rst_valid", o_valid, 0);
    check_val("rst_done", o_done, 0);
    check_val("rst_idx", o_idx, 0);
    check_val("rst_data", o_data, 0);
    check_val("rst_par", o_par, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Encrypt / decrypt with the DES test key, ready held high.
    run_sched(1'b0, KEY1, 1'b0, 100, -1, 1'b0);
    check_val("enc_K1_const", seen_q[0], DES_K1);
    check_val("enc_K16_const", seen_q[15], DES_K16);
    run_sched(1'b0, KEY1, 1'b1, 100, -1, 1'b0);
    check_val("dec_first_const", seen_q[0], DES_K16);
    check_val("dec_last_const", seen_q[15], DES_K1);

    // Backpressure, 30% ready.
    run_sched(1'b0, KEY1, 1'b0, 30, -1, 1'b0);
    run_sched(1'b0, KEY1, 1'b1, 30, -1, 1'b0);

    // Parity error on byte 0; round keys unchanged.
    run_sched(1'b0, KEY2, 1'b0, 100, -1, 1'b0);
    check_val("par_K1_const", seen_q[0], DES_K1);

    // Abort at idx 5 (with a simultaneous accept), then a clean run.
    run_sched(1'b0, KEY1, 1'b0, 100, 5, 1'b0);
    run_sched(1'b0, $urandom() ^ 64'h0, 1'b1, 50, -1, 1'b0);

    // Abort together with start in IDLE: start is dropped.
    sel = 1'b0; key = KEY1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check_val("idle_abort_busy", o_busy, 0);
    check_val("idle_abort_valid", o_valid, 0);

    // Asynchronous reset during WIND.
    key = KEY2; decrypt = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check_val("wind_busy", o_busy, 1);
    check_val("wind_par", o_par, 8'h01);
    #2 rst = 1'b1;
    #1;
    check_val("arst_busy", o_busy, 0);
    check_val("arst_valid", o_valid, 0);
    check_val("arst_done", o_done, 0);
    check_val("arst_idx", o_idx, 0);
    check_val("arst_data", o_data, 0);
    check_val("arst_par", o_par, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_sched(1'b0, {$urandom(), $urandom()}, 1'b0, 70, -1, 1'b0);

    // 4-round, single-shift schedule; start poked while busy.
    run_sched(1'b1, KEY1, 1'b0, 100, -1, 1'b1);
    check_val("b_K1_const", seen_q[0], DES_K1);
    run_sched(1'b1, KEY1, 1'b1, 100, -1, 1'b1);
    check_val("b_dec_last_const", seen_q[3], DES_K1);
    run_sched(1'b1, {$urandom(), $urandom()}, 1'b1, 40, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
